pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32: number of divider run cycles, legal range 2..63.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 rsD, rtD  input  5 each  source register numbers of the instruction in D.
REQ-005 branchD, jrD  input  1 each  D holds a branch / jump-register that resolves in D.
REQ-006 rtE  input  5  rt of the instruction in E.
REQ-007 writeregE  input  5  destination register of the instruction in E.
REQ-008 MemtoRegE, RegWriteE  input  1 each  E-stage load flag / register-write flag.
REQ-009 writeregM  input  5  destination register of the instruction in M.
REQ-010 MemtoRegM  input  1  M-stage load flag.
REQ-011 div_startE  input  1  E holds a div/divu; level, held while the instruction sits in E.
REQ-012 flush_except  input  1  exception or eret taken in M.
REQ-013 stallF, stallD, stallE  output  1 each  hold the PC, F/D and D/E pipeline registers.
REQ-014 flushD, flushE, flushM  output  1 each  clear the F/D, D/E and E/M pipeline registers.
REQ-015 div_busy  output  1  divider running; div_done  output  1  one-cycle result-valid strobe.

Function
REQ-016 lwstall SHALL be MemtoRegE & rtE!=0 & (rtE==rsD | rtE==rtD).
REQ-017 brstall SHALL be (branchD|jrD) & one of the following:
- RegWriteE & writeregE!=0 & writeregE matches rsD or rtD;
- MemtoRegM & writeregM!=0 & writeregM matches rsD or rtD.
REQ-018 The FSM SHALL have 3 states: IDLE, RUN, DONE. It SHALL use a 6-bit counter cnt.
REQ-019 IDLE -> RUN SHALL occur on div_startE & ~flush_except, with cnt<=0.
REQ-020 In RUN, cnt SHALL increment each cycle; RUN -> DONE SHALL occur when cnt==DIV_CYCLES-1.
REQ-021 DONE -> IDLE SHALL occur unconditionally; div_startE SHALL be ignored in DONE, so the completing instruction does not restart the divider.
REQ-022 divstall SHALL be (IDLE & div_startE) | RUN.
REQ-023 div_busy SHALL equal RUN; div_done SHALL equal DONE.
REQ-024 One divide SHALL give exactly DIV_CYCLES+1 cycles of stallE=1, followed by one cycle of div_done=1 with stallE=0.
REQ-025 Stall and flush outputs SHALL be:
- stallF = stallD = lwstall | brstall | divstall;
- stallE = divstall;
- flushE = (lwstall | brstall) & ~divstall;
- flushD = flushM = 0, except under REQ-026.
REQ-026 flush_except=1 SHALL override all other terms in the same cycle:
- flushD = flushE = flushM = 1;
- all stalls = 0;
- FSM -> IDLE and cnt <= 0 from any state, aborting a running divide with no div_done.
REQ-027 Stall and flush outputs SHALL be combinational from inputs and state, with no added latency.
REQ-028 lwstall and brstall asserted together SHALL produce one bubble per cycle: flushE=1, never a double insertion.
REQ-029 cnt SHALL never exceed DIV_CYCLES-1 and SHALL never wrap.

Reset
REQ-030 reset=1 at a clock edge SHALL set state IDLE and cnt 0.
REQ-031 While reset=1, all outputs SHALL be 0 regardless of other inputs.
REQ-032 reset during RUN SHALL abort the divide with no div_done pulse.

Verification
REQ-033 Load-use: MemtoRegE=1, rtE=5, rsD=5 -> stallF=stallD=1, flushE=1, stallE=0 for that cycle. With rtE=0 -> all outputs 0.
REQ-034 Branch hazard:
- branchD=1, RegWriteE=1, writeregE=8, rtD=8 -> stallD=1, flushE=1;
- next cycle MemtoRegM=1, writeregM=8 -> still stalled;
- then clear -> stalls 0.
REQ-035 Divide, DIV_CYCLES=32, div_startE held -> stallE=1 for 33 consecutive cycles, div_busy=1 for 32 of them, then div_done=1 and stallE=0 for exactly one cycle, then IDLE.
REQ-036 flush_except asserted at cnt=10 of RUN -> that cycle flushD=flushE=flushM=1 and all stalls 0; next cycle state IDLE, div_busy=0, and no div_done ever.
REQ-037 Synchronous reset pulse at cnt=20 -> outputs 0 during reset; after release state IDLE; a new div_startE yields a full 33-cycle stall.
REQ-038 Simultaneous lwstall and IDLE & div_startE -> stallF=stallD=stallE=1, flushE=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use and branch-operand
// stalls, multi-cycle divider sequencing, and exception flush.
module pipe_hazard_ctrl #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       branchD,
   input  logic       jrD,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic       MemtoRegE,
   input  logic       RegWriteE,
   input  logic [4:0] writeregM,
   input  logic       MemtoRegM,
   input  logic       div_startE,
   input  logic       flush_except,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       flushD,
   output logic       flushE,
   output logic       flushM,
   output logic       div_busy,
   output logic       div_done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [5:0] CntLast = 6'(DIV_CYCLES - 1);

   state_e     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       lwstall, brstall, divstall;

   // Data hazards seen by the instruction in D
   always_comb begin
      lwstall = MemtoRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
      brstall = (branchD || jrD) &&
                ((RegWriteE && (writeregE != 5'd0) &&
                  ((writeregE == rsD) || (writeregE == rtD))) ||
                 (MemtoRegM && (writeregM != 5'd0) &&
                  ((writeregM == rsD) || (writeregM == rtD))));
   end

   // Divider sequencer next state; an exception aborts from any state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_except) begin
         state_d = StIdle;
         cnt_d   = 6'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (div_startE) begin
                  state_d = StRun;
                  cnt_d   = 6'd0;
               end
            end
            StRun: begin
               if (cnt_q == CntLast) begin
                  state_d = StDone;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
            // div_startE is still high here; returning to idle without
            // looking at it keeps the finishing divide from re-launching
            StDone: begin
               state_d = StIdle;
               cnt_d   = 6'd0;
            end
            default: begin
               state_d = StIdle;
               cnt_d   = 6'd0;
            end
         endcase
      end
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall/flush outputs; reset forces all low, exception overrides stalls
   always_comb begin
      divstall = ((state_q == StIdle) && div_startE) || (state_q == StRun);
      stallF   = 1'b0;
      stallD   = 1'b0;
      stallE   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      flushM   = 1'b0;
      div_busy = 1'b0;
      div_done = 1'b0;
      if (!reset) begin
         div_busy = (state_q == StRun);
         div_done = (state_q == StDone);
         if (flush_except) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
         end else begin
            stallF = lwstall || brstall || divstall;
            stallD = lwstall || brstall || divstall;
            stallE = divstall;
            // One bubble into E; while E is held the D/E register must not be cleared
            flushE = (lwstall || brstall) && !divstall;
         end
      end
   end

endmodule
